// File: rtl/i2s_pkg.sv
// i2s_pkg
//   Types and constants shared by the I2S receive and transmit paths.
//   rx_state_t    : receive framing FSM states
//   chan_t        : channel select, encoded like LRCLK (0 = left, 1 = right)
//   I2S_DATA_W    : audio sample width used by both directions
//   sample_pair_t : one left/right sample pair, left in the upper half
package i2s_pkg;

  localparam int I2S_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } rx_state_t;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_t;

  typedef struct packed {
    logic [I2S_DATA_W-1:0] left;
    logic [I2S_DATA_W-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Generic single-clock FIFO with a combinational read port.
//   clk        : clock
//   srst       : synchronous active-high reset, empties the FIFO
//   push       : write push_data (ignored when full unless popping too)
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   pop_data   : head entry, valid while count != 0
//   count      : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic do_pop;
  logic do_push;
  logic is_full;

  assign is_full = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && (count_reg != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign do_push = push && (!is_full || do_pop);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer
//   I2S receiver: oversamples the codec's SCLK/LRCLK/Din in the CLK domain,
//   deserializes MSB-first left/right words and queues the pairs in a FIFO
//   presented as a valid/ready stream.
//   CLK, RESET          : system clock (>= 8x SCLK), synchronous active-high reset
//   SCLK, LRCLK, Din    : asynchronous I2S inputs from the codec (codec is master)
//   enable              : 1 = capture; 0 = stop capture, FIFO kept and poppable
//   sample_ready        : consumer accepts the head pair
//   overflow_clr        : clears the sticky overflow flag
//   sample_valid        : FIFO non-empty
//   sample_left/right   : head pair (zero while the FIFO is empty)
//   overflow            : sticky, a completed pair was dropped on a full FIFO
//   frame_err           : one-CLK pulse, a channel slot ended before DATA_W bits
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int DATA_W      = I2S_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCLK,
  input  logic              LRCLK,
  input  logic              Din,
  input  logic              enable,
  input  logic              sample_ready,
  input  logic              overflow_clr,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              overflow,
  output logic              frame_err
);

  localparam int BIT_CNT_W  = $clog2(DATA_W + 1);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(DATA_W - 1);

  // ---------------------------------------------------------------
  // Input synchronizers; bit order {SCLK, LRCLK, Din}
  // ---------------------------------------------------------------
  logic [2:0] async_in;
  logic [2:0] synced;

  assign async_in = {SCLK, LRCLK, Din};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain_reg;
    always_ff @(posedge CLK) begin
      if (RESET) chain_reg <= '0;
      else       chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};
    end
    assign synced[gi] = chain_reg[SYNC_STAGES-1];
  end

  logic sclk_s;
  logic lr_s;
  logic din_s;
  logic sclk_prev_reg;
  logic lr_prev_reg;
  logic bit_evt;
  logic lr_chg;

  assign sclk_s  = synced[2];
  assign lr_s    = synced[1];
  assign din_s   = synced[0];
  assign bit_evt = sclk_s && !sclk_prev_reg;
  assign lr_chg  = bit_evt && (lr_s != lr_prev_reg);

  // LRCLK history keeps tracking while disabled so that re-enable resyncs
  // on a genuine falling edge rather than a stale comparison.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sclk_prev_reg <= 1'b0;
      lr_prev_reg   <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      if (bit_evt) lr_prev_reg <= lr_s;
    end
  end

  // ---------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------
  rx_state_t state_reg;
  rx_state_t state_next;

  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  chan_t                chan_reg;
  logic [DATA_W-1:0]    shift_reg;
  logic [DATA_W-1:0]    shift_in;
  logic [DATA_W-1:0]    left_hold_reg;
  logic                 pair_done_reg;
  logic                 frame_err_reg;
  logic                 overflow_reg;

  logic start_slot;
  logic shift_en;
  logic last_bit;
  logic latch_left;
  logic pair_done_next;
  logic frame_err_next;

  assign shift_in = {shift_reg[DATA_W-2:0], din_s};

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = IDLE;
    end else if (bit_evt) begin
      case (state_reg)
        IDLE:  if (lr_chg && !lr_s) state_next = SHIFT;
        // A short slot aborts; if it ended on a falling edge the new left
        // slot starts right away.
        SHIFT: if (lr_chg)                         state_next = lr_s ? IDLE : SHIFT;
               else if (bit_cnt_reg == LAST_CNT) state_next = PAD;
        PAD:   if (lr_chg) state_next = SHIFT;
        default: state_next = IDLE;
      endcase
    end
  end

  // The bit sampled on an LRCLK change is the one-bit delay slot, so it
  // only ever restarts a slot and is never shifted in.
  always_comb begin
    start_slot     = 1'b0;
    shift_en       = 1'b0;
    frame_err_next = 1'b0;
    if (enable && bit_evt) begin
      case (state_reg)
        IDLE:  start_slot = lr_chg && !lr_s;
        SHIFT: begin
          if (lr_chg) begin
            frame_err_next = 1'b1;
            start_slot     = !lr_s;
          end else begin
            shift_en = 1'b1;
          end
        end
        PAD:   start_slot = lr_chg;
        default: ;
      endcase
    end
    last_bit       = shift_en && (bit_cnt_reg == LAST_CNT);
    latch_left     = last_bit && (chan_reg == CH_L);
    pair_done_next = last_bit && (chan_reg == CH_R);
  end

  // ---------------------------------------------------------------
  // Datapath and FIFO interface
  // ---------------------------------------------------------------
  logic [2*DATA_W-1:0]   head_data;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_full;
  logic                  fifo_pop;
  logic                  ovf_set;

  assign fifo_full = (fifo_count == FIFO_CNT_W'(FIFO_DEPTH));
  assign fifo_pop  = sample_valid && sample_ready;
  assign ovf_set   = pair_done_reg && fifo_full && !fifo_pop;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt_reg   <= '0;
      chan_reg      <= CH_L;
      shift_reg     <= '0;
      left_hold_reg <= '0;
      pair_done_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      pair_done_reg <= pair_done_next;
      frame_err_reg <= frame_err_next;
      if (start_slot) begin
        bit_cnt_reg <= '0;
        chan_reg    <= chan_t'(lr_s);
      end else if (shift_en) begin
        bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
        shift_reg   <= shift_in;
      end
      if (latch_left) left_hold_reg <= shift_in;
      if (ovf_set)           overflow_reg <= 1'b1;
      else if (overflow_clr) overflow_reg <= 1'b0;
    end
  end

  // The right word stays in shift_reg during PAD, so it is still intact
  // in the cycle after pair_done.
  sync_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .srst      (RESET),
    .push      (pair_done_reg),
    .push_data ({left_hold_reg, shift_reg}),
    .pop       (fifo_pop),
    .pop_data  (head_data),
    .count     (fifo_count)
  );

  assign sample_valid = (fifo_count != '0);
  assign sample_left  = sample_valid ? head_data[2*DATA_W-1:DATA_W] : '0;
  assign sample_right = sample_valid ? head_data[DATA_W-1:0] : '0;
  assign overflow     = overflow_reg;
  assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb_i2s_rx_deserializer
//   Directed bench: drives I2S frames bit by bit, keeps a queue model of
//   the pairs that must come out, and checks every accepted pair plus
//   frame_err/overflow behaviour at fixed points of each scenario.
module tb_i2s_rx_deserializer;
  import i2s_pkg::*;

  localparam int DATA_W     = 24;
  localparam int FIFO_DEPTH = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              SCLK;
  logic              LRCLK;
  logic              Din;
  logic              enable;
  logic              sample_ready;
  logic              overflow_clr;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_left;
  logic [DATA_W-1:0] sample_right;
  logic              overflow;
  logic              frame_err;

  always #5 CLK = ~CLK;

  i2s_rx_deserializer #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .SCLK         (SCLK),
    .LRCLK        (LRCLK),
    .Din          (Din),
    .enable       (enable),
    .sample_ready (sample_ready),
    .overflow_clr (overflow_clr),
    .sample_valid (sample_valid),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .overflow     (overflow),
    .frame_err    (frame_err)
  );

  int           tests = 0;
  int           fails = 0;
  sample_pair_t mdl_q[$];
  bit           exp_ovf = 1'b0;
  int           fe_cnt = 0;
  int           pop_cnt = 0;
  sample_pair_t last_pop = '0;
  logic         fe_prev = 1'b0;
  logic [DATA_W-1:0] pend_l;
  logic [DATA_W-1:0] pend_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A completed pair enters the model FIFO, or is dropped when it is full.
  task automatic model_push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    sample_pair_t p;
    p.left  = l;
    p.right = r;
    if (mdl_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
    else mdl_q.push_back(p);
  endtask

  // Compare process: every accepted pair must be the model's head.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (frame_err) begin
        fe_cnt++;
        check("frame_err_width", {63'd0, fe_prev}, 64'd0);
      end
      if (sample_valid && sample_ready) begin
        if (mdl_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pair: got %h_%h expected none", sample_left, sample_right);
        end else begin
          sample_pair_t e;
          e = mdl_q.pop_front();
          check("pair_left", {40'd0, sample_left}, {40'd0, e.left});
          check("pair_right", {40'd0, sample_right}, {40'd0, e.right});
          $display("[TB] pair %h %h", sample_left, sample_right);
        end
        last_pop.left  = sample_left;
        last_pop.right = sample_right;
        pop_cnt++;
      end
    end
    fe_prev = frame_err;
  end

  // One SCLK period (10 CLK); the DUT samples on the rising edge.
  task automatic send_bit(input logic lr, input logic d, input bit mark);
    LRCLK = lr;
    Din   = d;
    #50;
    SCLK = 1'b1;
    if (mark) model_push(pend_l, pend_r);
    #50;
    SCLK = 1'b0;
  endtask

  // Slot: delay bit (driven 1), DATA_W data bits MSB first, then pad.
  task automatic send_slot(input logic lr, input logic [DATA_W-1:0] data, input int slot, input bit rec);
    for (int k = 0; k < slot; k++) begin
      if (k == 0)            send_bit(lr, 1'b1, 1'b0);
      else if (k <= DATA_W)  send_bit(lr, data[DATA_W-k], rec && (k == DATA_W));
      else                   send_bit(lr, k[0], 1'b0);
    end
  endtask

  task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input int slot, input bit rec);
    pend_l = l;
    pend_r = r;
    send_slot(1'b0, l, slot, 1'b0);
    send_slot(1'b1, r, slot, rec);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (mdl_q.size() != 0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    repeat (10) @(posedge CLK);
    #1;
    check({name, "_drained"}, 64'(mdl_q.size()), 64'd0);
    check({name, "_valid_low"}, {63'd0, sample_valid}, 64'd0);
  endtask

  task automatic at_pos();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] v;
    RESET = 1'b1; SCLK = 1'b0; LRCLK = 1'b1; Din = 1'b0;
    enable = 1'b1; sample_ready = 1'b1; overflow_clr = 1'b0;
    repeat (4) at_pos();
    check("rst_valid", {63'd0, sample_valid}, 64'd0);
    check("rst_left", {40'd0, sample_left}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_ferr", {63'd0, frame_err}, 64'd0);
    RESET = 1'b0;
    #3;

    // 1: basic 32-bit slots, preceded by some right-channel bits
    pop_cnt = 0;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
    send_pair(24'hABCDEF, 24'h123456, 32, 1'b1);
    wait_drain("t1");
    check("t1_pops", 64'(pop_cnt), 64'd1);
    check("t1_pair", 64'(last_pop), {16'd0, 24'hABCDEF, 24'h123456});
    check("t1_ferr", 64'(fe_cnt), 64'd0);

    // 2: disabled mid-left, re-enabled mid-right: resync on falling edge
    enable = 1'b0;
    pop_cnt = 0;
    send_slot(1'b0, 24'h777777, 13, 1'b0);
    send_slot(1'b1, 24'h000000, 6, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b1, i[0], 1'b0);
    send_pair(24'h2468AC, 24'h13579B, 32, 1'b1);
    wait_drain("t2");
    check("t2_pops", 64'(pop_cnt), 64'd1);
    check("t2_pair", 64'(last_pop), {16'd0, 24'h2468AC, 24'h13579B});
    check("t2_ferr", 64'(fe_cnt), 64'd0);

    // 3a: left slot cut after 10 bits
    pop_cnt = 0;
    send_slot(1'b0, 24'hFFFFFF, 11, 1'b0);
    send_slot(1'b1, 24'h0F0F0F, 32, 1'b0);
    send_pair(24'h000001, 24'h800000, 32, 1'b1);
    wait_drain("t3a");
    check("t3a_ferr", 64'(fe_cnt), 64'd1);
    check("t3a_pops", 64'(pop_cnt), 64'd1);
    check("t3a_pair", 64'(last_pop), {16'd0, 24'h000001, 24'h800000});

    // 3b: right slot cut by a falling edge restarts left immediately
    pop_cnt = 0;
    send_slot(1'b0, 24'hC0FFEE, 32, 1'b0);
    send_slot(1'b1, 24'hFFFFFF, 6, 1'b0);
    send_pair(24'h00FACE, 24'hBEEF00, 32, 1'b1);
    wait_drain("t3b");
    check("t3b_ferr", 64'(fe_cnt), 64'd2);
    check("t3b_pops", 64'(pop_cnt), 64'd1);
    check("t3b_pair", 64'(last_pop), {16'd0, 24'h00FACE, 24'hBEEF00});

    // 4: overflow with consumer stalled
    at_pos();
    sample_ready = 1'b0;
    pop_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      v = 24'(24'h111111 * (i + 1));
      send_pair(v, ~v, 32, 1'b1);
    end
    repeat (30) at_pos();
    check("t4_ovf_model", {63'd0, overflow}, {63'd0, exp_ovf});
    check("t4_ovf", {63'd0, overflow}, 64'd1);
    check("t4_count", 64'(dut.fifo_count), 64'd4);
    check("t4_valid", {63'd0, sample_valid}, 64'd1);
    sample_ready = 1'b1;
    wait_drain("t4");
    check("t4_pops", 64'(pop_cnt), 64'd4);
    check("t4_last", 64'(last_pop), {16'd0, 24'h444444, 24'hBBBBBB});
    check("t4_ovf_sticky", {63'd0, overflow}, 64'd1);
    overflow_clr = 1'b1;
    at_pos();
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    check("t4_ovf_clr", {63'd0, overflow}, 64'd0);

    // 5: minimum 25-bit slots
    pop_cnt = 0;
    send_pair(24'hFFFFFF, 24'h000000, 25, 1'b1);
    send_pair(24'h800001, 24'h7FFFFE, 25, 1'b1);
    wait_drain("t5");
    check("t5_pops", 64'(pop_cnt), 64'd2);
    check("t5_last", 64'(last_pop), {16'd0, 24'h800001, 24'h7FFFFE});
    check("t5_ferr", 64'(fe_cnt), 64'd2);

    // 6: reset mid-left-slot with two pairs buffered
    at_pos();
    sample_ready = 1'b0;
    send_pair(24'h0000AA, 24'h00BB00, 32, 1'b1);
    send_pair(24'hCC0000, 24'h0000DD, 32, 1'b1);
    send_slot(1'b0, 24'h333333, 9, 1'b0);
    repeat (5) at_pos();
    check("t6_count", 64'(dut.fifo_count), 64'(mdl_q.size()));
    RESET = 1'b1;
    at_pos();
    check("t6_valid", {63'd0, sample_valid}, 64'd0);
    check("t6_left", {40'd0, sample_left}, 64'd0);
    check("t6_right", {40'd0, sample_right}, 64'd0);
    check("t6_ovf", {63'd0, overflow}, 64'd0);
    check("t6_ferr", {63'd0, frame_err}, 64'd0);
    mdl_q.delete();
    repeat (2) at_pos();
    RESET = 1'b0;
    sample_ready = 1'b1;
    pop_cnt = 0;
    for (int i = 0; i < 15; i++) send_bit(1'b0, 1'b1, 1'b0);
    send_slot(1'b1, 24'h000000, 32, 1'b0);
    send_pair(24'h5A5A5A, 24'hA5A5A5, 32, 1'b1);
    wait_drain("t6");
    check("t6_pops", 64'(pop_cnt), 64'd1);
    check("t6_pair", 64'(last_pop), {16'd0, 24'h5A5A5A, 24'hA5A5A5});
    check("t6_ferr_cnt", 64'(fe_cnt), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deserializer.md
Name: i2s_rx_deserializer

Overview:
- I2S receive path: takes codec ADC serial data (Din, SCLK, LRCLK) and deserializes it into 24-bit left/right sample pairs in the CLK domain.
- Pairs are buffered in a small FIFO and presented on a valid/ready stream to the synth/effects datapath, which feeds the I2S transmit path.
- Codec is bus master: SCLK and LRCLK are inputs, sampled as data, never used as clocks.

Parameters:
DATA_W, 24, sample width captured per channel, MSB first
SYNC_STAGES, 2, synchronizer flops on SCLK/LRCLK/Din (min 2)
FIFO_DEPTH, 4, sample-pair entries (power of 2, min 2)

Ports:
CLK  in  1  system clock, sole clock; must be at least 8x SCLK frequency
RESET  in  1  synchronous, active-high reset
SCLK  in  1  I2S bit clock from codec, asynchronous
LRCLK  in  1  I2S word select, asynchronous; 0 = left, 1 = right
Din  in  1  I2S serial data from codec ADC
enable  in  1  1 = receive; 0 = stop capture and hold the FIFO
sample_ready  in  1  consumer accepts the head pair
overflow_clr  in  1  clears the sticky overflow flag
sample_valid  out  1  FIFO non-empty
sample_left  out  DATA_W  head pair, left channel
sample_right  out  DATA_W  head pair, right channel
overflow  out  1  sticky; a completed pair was dropped because the FIFO was full
frame_err  out  1  one-CLK pulse; channel slot ended before DATA_W bits were captured

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE, synchronizers cleared, prev-LRCLK register 0.
- Synchronization: SCLK, LRCLK and Din each pass through SYNC_STAGES flops. bit_evt = synchronized SCLK rises (previous 0, current 1), one CLK wide. LRCLK_s and Din_s are sampled only on bit_evt.
- lr_chg = on bit_evt, LRCLK_s differs from the LRCLK_s captured at the previous bit_evt.
- The bit sampled at the lr_chg event is the I2S one-bit delay slot. It is always discarded. The MSB is captured on the next bit_evt.
- FSM, transitions evaluated only on bit_evt; enable=0 forces IDLE in any cycle:
  - IDLE: wait for lr_chg with LRCLK_s=0 (falling edge = left start). Then bit_cnt<=0, chan<=L, go to SHIFT.
  - SHIFT: shift Din_s into the channel shift register, bit_cnt++. When bit_cnt reaches DATA_W, go to PAD.
    - If chan=L, latch left_hold.
    - If chan=R, assert pair_done for 1 CLK.
  - PAD: ignore bits. On lr_chg, chan<=LRCLK_s, bit_cnt<=0, go to SHIFT.
  - lr_chg while in SHIFT (short slot): pulse frame_err, discard the partial word and any held left word, then go to IDLE. If this same lr_chg is a falling edge, it restarts capture immediately as in IDLE.
  - lr_chg in PAD where the new LRCLK_s equals chan (missed edge): impossible by construction. A change from R to L while awaiting R is handled as a short slot.
- Minimum valid slot is DATA_W+1 SCLK periods. Longer slots (e.g. 32) are padded and ignored.
- FIFO push:
  - Cycle after pair_done: write {left_hold, right_shift}.
  - If the FIFO is full, the pair is dropped and overflow<=1.
  - overflow_clr clears overflow. A set in the same cycle wins over the clear.
- FIFO pop: on sample_valid && sample_ready.
  - Outputs show the head entry combinationally from the FIFO read port.
  - Simultaneous push and pop when full is legal: the pop frees the slot, so no overflow.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- Latency: last right bit captured in CLK N, FIFO write in N+1, sample_valid=1 in N+2. Pin-to-capture adds SYNC_STAGES+1 CLK.
- Arithmetic: the shift register holds exactly DATA_W bits. Two's complement is passed through unmodified; no sign extension or scaling.
- enable=0 mid-frame: partial pair discarded with no frame_err, FIFO retained, pops still allowed. On re-enable, the FSM resyncs on the next LRCLK falling edge.
- RESET mid-frame: identical to power-up reset; FIFO contents are lost.

Decomposition:
- Shared package i2s_pkg holds:
  - rx_state_t enum {IDLE, SHIFT, PAD}
  - chan_t enum {CH_L=0, CH_R=1}
  - I2S_DATA_W=24 localparam, shared with the transmit path
  - sample_pair_t packed struct {left, right}
- One sub-module: sync_fifo, a generic synchronous FIFO parameterized by width and depth, with a count output.

Test Plan:
- 32-bit slots, left=24'hABCDEF, right=24'h123456, ready=1 -> exactly one sample_valid pulse with those values. The discarded delay bit, driven as 1, must not appear in either sample.
- Stream starts mid-right slot -> no output until the first LRCLK falling edge. First pair out equals the first complete L/R pair sent.
- LRCLK toggles after 10 left bits -> frame_err pulses 1 CLK, no push. The following pair (left=24'h000001, right=24'h800000) is received intact.
- ready=0, send 5 pairs P0..P4 with depth 4 -> overflow=1 after P4, count=4. Drain yields P0..P3 in order. overflow_clr -> overflow=0.
- 25-bit slots (minimum), left=24'hFFFFFF, right=24'h000000 -> pairs received correctly, no frame_err.
- RESET asserted mid-left-slot with 2 pairs in the FIFO -> next CLK sample_valid=0 and all outputs 0. Capture resumes correctly at the next LRCLK falling edge.
